// File: rtl/i2s_tx_scheduler.sv
// I2S master transmitter: derives BCK/LRCK from clk, fetches one {left,right}
// word per frame from a valid/ready source and shifts it out MSB-first with
// the standard one-BCK delay after each LRCK edge.
module i2s_tx_scheduler #(
    parameter int CLK_DIV      = 4,
    parameter int BCK_PER_HALF = 32,
    parameter int SAMPLE_BITS  = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [2*SAMPLE_BITS-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     bck,
    output logic                     lrck,
    output logic                     sdata,
    output logic                     frame_start,
    output logic [15:0]              underrun_count
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * BCK_PER_HALF);
    localparam int WORD_W = 2 * SAMPLE_BITS;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * BCK_PER_HALF - 1);
    localparam logic [BIT_W-1:0] HALF     = BIT_W'(BCK_PER_HALF);
    localparam logic [BIT_W-1:0] NBITS    = BIT_W'(SAMPLE_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic                r_bck;
    logic                r_lrck;
    logic                r_sdata;
    logic                r_frame_start;
    logic [WORD_W-1:0]   r_shift;
    logic [15:0]         r_underrun;

    logic                w_tick;
    logic                w_fall;
    logic                w_wrap;
    logic                w_drain_done;
    logic [BIT_W-1:0]    w_bit_nxt;
    logic                w_lrck_nxt;
    logic [BIT_W-1:0]    w_pos;
    logic                w_slot;

    // Divider tick, BCK falling-edge tick, frame wrap and next bit position.
    always_comb begin
        w_tick     = (r_state != S_IDLE) && (r_div_cnt == DIV_LAST);
        w_fall     = w_tick && r_bck;
        w_wrap     = w_fall && (r_bit_cnt == BIT_LAST);
        w_bit_nxt  = w_wrap ? '0 : r_bit_cnt + 1'b1;
        w_lrck_nxt = (w_bit_nxt >= HALF);
        w_pos      = w_lrck_nxt ? (w_bit_nxt - HALF) : w_bit_nxt;
        w_slot     = (w_pos != '0) && (w_pos <= NBITS);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; in_ready is only offered at a frame wrap while running.
    always_comb begin
        w_state_nxt  = r_state;
        in_ready     = 1'b0;
        w_drain_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                in_ready = w_wrap;
                if (!enable) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (enable) begin
                    w_state_nxt = S_RUN;
                end else if (w_wrap) begin
                    w_state_nxt  = S_IDLE;
                    w_drain_done = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Clock generation and pin timing; leaving IDLE preloads the last bit so
    // the first falling BCK edge is a wrap that fetches the first word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_bck         <= 1'b0;
            r_lrck        <= 1'b0;
            r_sdata       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            if (r_state == S_IDLE) begin
                r_div_cnt <= '0;
                r_lrck    <= 1'b0;
                r_sdata   <= 1'b0;
                r_bit_cnt <= enable ? BIT_LAST : '0;
                r_bck     <= enable;
            end else if (w_drain_done) begin
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
                r_bck     <= 1'b0;
                r_lrck    <= 1'b0;
                r_sdata   <= 1'b0;
            end else begin
                r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
                if (w_tick) r_bck <= ~r_bck;
                if (w_fall) begin
                    r_bit_cnt <= w_bit_nxt;
                    r_lrck    <= w_lrck_nxt;
                    r_sdata   <= w_slot & r_shift[WORD_W-1];
                end
            end
        end
    end

    // Word fetch, serial shift-out and saturating underrun count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift    <= '0;
            r_underrun <= '0;
        end else begin
            if (in_ready) begin
                r_shift <= in_valid ? in_data : '0;
            end else if (w_fall && w_slot) begin
                r_shift <= {r_shift[WORD_W-2:0], 1'b0};
            end
            if (in_ready && !in_valid && (r_underrun != '1)) begin
                r_underrun <= r_underrun + 1'b1;
            end
        end
    end

    assign bck            = r_bck;
    assign lrck           = r_lrck;
    assign sdata          = r_sdata;
    assign frame_start    = r_frame_start;
    assign underrun_count = r_underrun;

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Bench for i2s_tx_scheduler: a FIFO source, an I2S decoder on the pins and
// a frame-level model (one fetch per frame, zero word and count on empty).
module tb_i2s_tx_scheduler;

    localparam int CD  = 2;
    localparam int BPH = 32;
    localparam int SB  = 24;
    localparam int unsigned FRAME = 2 * BPH * 2 * CD;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b1;
    logic          enable   = 1'b0;
    logic [47:0]   in_data  = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, bck, lrck, sdata, frame_start;
    logic [15:0]   underrun_count;

    i2s_tx_scheduler #(.CLK_DIV(CD), .BCK_PER_HALF(BPH), .SAMPLE_BITS(SB)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .bck(bck), .lrck(lrck),
        .sdata(sdata), .frame_start(frame_start), .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int passed = 0;
    int total  = 0;

    // Source FIFO and event logs, evaluated mid-cycle.
    logic [47:0] tx_q[$];
    bit          pend = 0;
    int unsigned rdy_cyc[$];
    int unsigned fs_cyc[$];
    int unsigned lr_cyc[$];
    logic        lr_prev = 1'b0;

    always @(negedge clk) begin
        if (pend) begin
            void'(tx_q.pop_front());
            pend = 0;
        end
        in_valid = (tx_q.size() > 0);
        in_data  = in_valid ? tx_q[0] : {16'($urandom), $urandom};
        if (in_ready) rdy_cyc.push_back(cyc);
        if (frame_start) fs_cyc.push_back(cyc);
        if (lrck && !lr_prev) lr_cyc.push_back(cyc);
        lr_prev = lrck;
        pend = in_ready && in_valid;
    end

    // I2S receiver: bit 0 after each LRCK edge is the delay slot, then MSB first.
    int          dec_idx = -1;
    int unsigned last_rise = 0;
    logic        prev_l = 1'b0;
    logic [SB-1:0] lw = '0, rw = '0;
    bit          ldone = 0;
    logic [47:0] rx_q[$];
    int          pad_err = 0;

    always @(posedge bck) begin
        if (cyc - last_rise > 8) begin
            dec_idx = -1;
            ldone   = 0;
        end else if (lrck != prev_l) begin
            dec_idx = 0;
        end else begin
            dec_idx++;
        end
        if (dec_idx == 0 && !lrck) ldone = 0;
        prev_l    = lrck;
        last_rise = cyc;
        if (dec_idx >= 1 && dec_idx <= SB) begin
            if (!lrck) lw = {lw[SB-2:0], sdata};
            else       rw = {rw[SB-2:0], sdata};
        end else if (sdata) begin
            pad_err++;
        end
        if (!lrck && dec_idx == SB) ldone = 1;
        if (lrck && dec_idx == SB && ldone) rx_q.push_back({lw, rw});
    end

    // Frame-level reference model.
    logic [47:0] mq[$];
    logic [47:0] exp_rx[$];
    int unsigned exp_urun = 0;

    function automatic void push_word(input logic [47:0] w);
        mq.push_back(w);
        tx_q.push_back(w);
    endfunction

    function automatic void model_fetch();
        if (mq.size() > 0) begin
            exp_rx.push_back(mq.pop_front());
        end else begin
            exp_rx.push_back('0);
            if (exp_urun < 32'hFFFF) exp_urun++;
        end
    endfunction

    function automatic void clear_logs();
        rdy_cyc.delete();
        fs_cyc.delete();
        lr_cyc.delete();
        rx_q.delete();
        exp_rx.delete();
        pad_err = 0;
    endfunction

    function automatic logic [47:0] rnd48();
        return {16'($urandom), $urandom};
    endfunction

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic test_reset();
        enable = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        total++;
        if ({bck, lrck, sdata, in_ready, frame_start} !== 5'b0)
            $display("FAIL reset_pins: got %b expected 00000", {bck, lrck, sdata, in_ready, frame_start});
        else passed++;
        total++;
        if (underrun_count !== 16'h0)
            $display("FAIL reset_underrun: got %h expected 0000", underrun_count);
        else passed++;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        exp_urun = 0;
        repeat (4) @(negedge clk);
        total++;
        if ({bck, lrck, sdata, in_ready, frame_start} !== 5'b0)
            $display("FAIL idle_pins: got %b expected 00000", {bck, lrck, sdata, in_ready, frame_start});
        else passed++;
    endtask

    task automatic test_single_word();
        logic [47:0] w;
        int unsigned k;
        clear_logs();
        w = rnd48();
        push_word(w);
        @(negedge clk);
        enable = 1'b1;
        k = cyc;
        model_fetch();
        wait_until(k + 22);
        enable = 1'b0;
        wait_until(k + 300);
        total++;
        if (rdy_cyc.size() != 1) $display("FAIL single_rdy_count: got %0d expected 1", rdy_cyc.size());
        else passed++;
        total++;
        if ((rdy_cyc.size() > 0 ? rdy_cyc[0] : 0) != k + 2)
            $display("FAIL single_rdy_time: got %0d expected %0d", rdy_cyc.size() > 0 ? rdy_cyc[0] : 0, k + 2);
        else passed++;
        total++;
        if (fs_cyc.size() != 2 || fs_cyc[0] != k + 3 || fs_cyc[1] != k + 3 + FRAME)
            $display("FAIL single_frame_start: got %0d pulses first %0d expected 2 at %0d,%0d",
                     fs_cyc.size(), fs_cyc.size() > 0 ? fs_cyc[0] : 0, k + 3, k + 3 + FRAME);
        else passed++;
        total++;
        if (rx_q.size() != 1 || rx_q[0] !== exp_rx[0])
            $display("FAIL single_word: got %0d words first %h expected 1 word %h",
                     rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 48'h0, exp_rx[0]);
        else passed++;
        total++;
        if ({bck, lrck, sdata} !== 3'b0) $display("FAIL single_idle_pins: got %b expected 000", {bck, lrck, sdata});
        else passed++;
    endtask

    task automatic test_underrun();
        int unsigned k;
        clear_logs();
        @(negedge clk);
        enable = 1'b1;
        k = cyc;
        repeat (3) model_fetch();
        wait_until(k + 600);
        push_word(48'h800000_7FFFFF);
        model_fetch();
        wait_until(k + 800);
        enable = 1'b0;
        wait_until(k + 1100);
        total++;
        if (rdy_cyc.size() != 4) $display("FAIL urun_rdy_count: got %0d expected 4", rdy_cyc.size());
        else passed++;
        for (int i = 0; i < rdy_cyc.size(); i++) begin
            total++;
            if (rdy_cyc[i] != k + 2 + FRAME * i)
                $display("FAIL urun_rdy_time[%0d]: got %0d expected %0d", i, rdy_cyc[i], k + 2 + FRAME * i);
            else passed++;
        end
        total++;
        if (rx_q.size() != exp_rx.size()) $display("FAIL urun_rx_count: got %0d expected %0d", rx_q.size(), exp_rx.size());
        else passed++;
        for (int i = 0; i < rx_q.size() && i < exp_rx.size(); i++) begin
            total++;
            if (rx_q[i] !== exp_rx[i]) $display("FAIL urun_word[%0d]: got %h expected %h", i, rx_q[i], exp_rx[i]);
            else passed++;
        end
        total++;
        if (underrun_count !== 16'(exp_urun)) $display("FAIL urun_count: got %h expected %h", underrun_count, 16'(exp_urun));
        else passed++;
        total++;
        if (pad_err != 0) $display("FAIL urun_pad_bits: got %0d nonzero pad bits expected 0", pad_err);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int unsigned k;
        clear_logs();
        for (int i = 0; i < 4; i++) push_word(rnd48());
        @(negedge clk);
        enable = 1'b1;
        k = cyc;
        repeat (4) model_fetch();
        wait_until(k + 2 + 3 * FRAME + 20);
        enable = 1'b0;
        wait_until(k + 1100);
        total++;
        if (rdy_cyc.size() != 4) $display("FAIL b2b_rdy_count: got %0d expected 4", rdy_cyc.size());
        else passed++;
        for (int i = 0; i < rdy_cyc.size(); i++) begin
            total++;
            if (rdy_cyc[i] != k + 2 + FRAME * i)
                $display("FAIL b2b_rdy_time[%0d]: got %0d expected %0d", i, rdy_cyc[i], k + 2 + FRAME * i);
            else passed++;
        end
        total++;
        if (rx_q.size() != 4) $display("FAIL b2b_rx_count: got %0d expected 4", rx_q.size());
        else passed++;
        for (int i = 0; i < rx_q.size() && i < exp_rx.size(); i++) begin
            total++;
            if (rx_q[i] !== exp_rx[i]) $display("FAIL b2b_word[%0d]: got %h expected %h", i, rx_q[i], exp_rx[i]);
            else passed++;
        end
        total++;
        if (lr_cyc.size() != 4 || lr_cyc[0] != k + 3 + FRAME / 2)
            $display("FAIL b2b_lrck_first: got %0d rises first %0d expected 4 first %0d",
                     lr_cyc.size(), lr_cyc.size() > 0 ? lr_cyc[0] : 0, k + 3 + FRAME / 2);
        else passed++;
        for (int i = 1; i < lr_cyc.size(); i++) begin
            total++;
            if (lr_cyc[i] - lr_cyc[i-1] != FRAME)
                $display("FAIL b2b_lrck_period[%0d]: got %0d expected %0d", i, lr_cyc[i] - lr_cyc[i-1], FRAME);
            else passed++;
        end
        total++;
        if (underrun_count !== 16'(exp_urun)) $display("FAIL b2b_underrun: got %h expected %h", underrun_count, 16'(exp_urun));
        else passed++;
    endtask

    task automatic test_drain();
        int unsigned k, k2;
        int bad;
        clear_logs();
        push_word(rnd48());
        push_word(rnd48());
        @(negedge clk);
        enable = 1'b1;
        k = cyc;
        model_fetch();
        wait_until(k + 43);
        enable = 1'b0;
        wait_until(k + 3 + FRAME);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (bck || lrck || sdata) bad++;
            @(negedge clk);
        end
        total++;
        if (bad != 0) $display("FAIL drain_idle_pins: got %0d active cycles expected 0", bad);
        else passed++;
        total++;
        if (tx_q.size() != 1) $display("FAIL drain_no_fetch: got %0d queued expected 1", tx_q.size());
        else passed++;
        enable = 1'b1;
        k2 = cyc;
        model_fetch();
        wait_until(k2 + 50);
        enable = 1'b0;
        wait_until(k2 + 100);
        enable = 1'b1;
        model_fetch();
        wait_until(k2 + 280);
        enable = 1'b0;
        wait_until(k2 + 560);
        total++;
        if (rdy_cyc.size() != 3 || rdy_cyc[0] != k + 2 || rdy_cyc[1] != k2 + 2 || rdy_cyc[2] != k2 + 2 + FRAME)
            $display("FAIL drain_rdy_times: got %0d pulses expected 3 at %0d,%0d,%0d",
                     rdy_cyc.size(), k + 2, k2 + 2, k2 + 2 + FRAME);
        else passed++;
        total++;
        if (fs_cyc.size() != 5 || fs_cyc[1] != k + 3 + FRAME)
            $display("FAIL drain_frame_start: got %0d pulses second %0d expected 5 second %0d",
                     fs_cyc.size(), fs_cyc.size() > 1 ? fs_cyc[1] : 0, k + 3 + FRAME);
        else passed++;
        total++;
        if (rx_q.size() != exp_rx.size()) $display("FAIL drain_rx_count: got %0d expected %0d", rx_q.size(), exp_rx.size());
        else passed++;
        for (int i = 0; i < rx_q.size() && i < exp_rx.size(); i++) begin
            total++;
            if (rx_q[i] !== exp_rx[i]) $display("FAIL drain_word[%0d]: got %h expected %h", i, rx_q[i], exp_rx[i]);
            else passed++;
        end
        total++;
        if (underrun_count !== 16'(exp_urun)) $display("FAIL drain_underrun: got %h expected %h", underrun_count, 16'(exp_urun));
        else passed++;
    endtask

    task automatic test_reset_mid();
        int unsigned k, k2;
        clear_logs();
        push_word(rnd48());
        push_word(rnd48());
        @(negedge clk);
        enable = 1'b1;
        k = cyc;
        model_fetch();
        void'(exp_rx.pop_back());
        wait_until(k + 150);
        total++;
        if (underrun_count !== 16'(exp_urun)) $display("FAIL pre_reset_underrun: got %h expected %h", underrun_count, 16'(exp_urun));
        else passed++;
        reset_n = 1'b0;
        enable  = 1'b0;
        exp_urun = 0;
        #1;
        total++;
        if ({bck, lrck, sdata, in_ready, frame_start} !== 5'b0 || underrun_count !== 16'h0)
            $display("FAIL midreset_outputs: got pins %b count %h expected 00000 0000",
                     {bck, lrck, sdata, in_ready, frame_start}, underrun_count);
        else passed++;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if ({bck, lrck, sdata} !== 3'b0) $display("FAIL midreset_no_restart: got %b expected 000", {bck, lrck, sdata});
        else passed++;
        enable = 1'b1;
        k2 = cyc;
        model_fetch();
        wait_until(k2 + 30);
        enable = 1'b0;
        wait_until(k2 + 300);
        total++;
        if (rdy_cyc.size() != 2 || rdy_cyc[1] != k2 + 2)
            $display("FAIL midreset_rdy: got %0d pulses expected 2 with second at %0d", rdy_cyc.size(), k2 + 2);
        else passed++;
        total++;
        if (rx_q.size() != 1 || rx_q[0] !== exp_rx[0])
            $display("FAIL midreset_word: got %0d words first %h expected 1 word %h",
                     rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 48'h0, exp_rx[0]);
        else passed++;
    endtask

    task automatic test_saturation();
        int unsigned k;
        clear_logs();
        force dut.r_underrun = 16'hFFFE;
        @(negedge clk);
        release dut.r_underrun;
        exp_urun = 32'hFFFE;
        @(negedge clk);
        enable = 1'b1;
        k = cyc;
        model_fetch();
        wait_until(k + 4);
        total++;
        if (underrun_count !== 16'(exp_urun)) $display("FAIL sat_first: got %h expected %h", underrun_count, 16'(exp_urun));
        else passed++;
        model_fetch();
        wait_until(k + 262);
        total++;
        if (underrun_count !== 16'(exp_urun)) $display("FAIL sat_hold: got %h expected %h", underrun_count, 16'(exp_urun));
        else passed++;
        model_fetch();
        wait_until(k + 520);
        total++;
        if (underrun_count !== 16'(exp_urun)) $display("FAIL sat_hold2: got %h expected %h", underrun_count, 16'(exp_urun));
        else passed++;
        enable = 1'b0;
        wait_until(k + 800);
        total++;
        if (rx_q.size() != 3 || rx_q[0] !== 48'h0 || rx_q[2] !== 48'h0)
            $display("FAIL sat_zero_words: got %0d words first %h expected 3 zero words",
                     rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 48'h0);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_underrun();
        test_back_to_back();
        test_drain();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
